wordle_guess_scorer: RTL and testbench
======================================

Name: wordle_guess_scorer

Overview:
- Parametrised Wordle scoring engine with per-guess history storage.
- Accepts a target word and then guesses through a valid/ready handshake.
- Scores each guess with exact Wordle duplicate-letter rules, using a two-pass sequential scan of one letter per cycle.
- Stores the scored rows and exposes a registered read port so the VGA pixel path can fetch tile colour and character.
- Tracks guess count and the win/lose flags. Sits between the game state machine and the VGA colour logic in wordle_top.

Parameters:
WORD_LEN, 5, letters per word (2..8)
CHAR_W, 8, bits per character (ASCII)
MAX_GUESSES, 6, history rows (1..8)
ROW_W, 3, row-index width, >= clog2(MAX_GUESSES+1)
COL_W, 3, column-index width, >= clog2(WORD_LEN+1)

Ports:
board_clk  in  1  clock
reset  in  1  asynchronous, active-high; clock board_clk
clear  in  1  synchronous new-game: wipes history, count and flags; aborts scoring
target_load  in  1  one-cycle strobe; latch target_word (IDLE only)
target_word  in  WORD_LEN*CHAR_W  secret word, letter 0 in MSBs
guess_valid  in  1  guess offered
guess_word  in  WORD_LEN*CHAR_W  guess, letter 0 in MSBs
guess_ready  out  1  engine can accept a guess
busy  out  1  scoring in progress
score_done  out  1  one-cycle pulse, row committed
score_colors  out  2*WORD_LEN  codes for the last committed row, letter 0 in MSBs
score_row  out  ROW_W  row index just committed
guess_count  out  ROW_W  number of rows committed
win  out  1  sticky, set when a row is all GREEN
lose  out  1  sticky, set when MAX_GUESSES rows are committed without a win
rd_row  in  ROW_W  display read row
rd_col  in  COL_W  display read column
rd_rgb  out  3  {R,G,B} tile colour, one-cycle latency
rd_char  out  CHAR_W  stored character, one-cycle latency

Behaviour:
- Colour codes: 00 EMPTY, 01 ABSENT, 10 YELLOW, 11 GREEN.
- RGB mapping: EMPTY 3'b111, ABSENT 3'b101, YELLOW 3'b110, GREEN 3'b010.
- Reset values: all outputs 0, except guess_ready 0 until a target is loaded. All history codes are EMPTY and all characters are 8'h20. target_valid=0.
- States: IDLE, GREEN, YELLOW, COMMIT.
- target_load in IDLE latches the target, sets target_valid and performs an implicit clear. target_load outside IDLE is ignored.
- guess_ready = IDLE & target_valid & ~win & ~lose & ~clear.
- Accept happens on the edge where guess_valid & guess_ready. That edge latches guess_word, zeroes the per-letter used[] mask and the index i, and moves to GREEN. busy is high from that edge until COMMIT exits.
- GREEN (WORD_LEN cycles, i=0..WORD_LEN-1): if guess[i]==target[i], code[i]=GREEN and used[i]=1; otherwise code[i]=ABSENT (provisional). After the last letter, go to YELLOW with i=0.
- YELLOW (WORD_LEN cycles): for each i whose code is not GREEN, find the lowest j with ~used[j] & target[j]==guess[i].
  - If found: code[i]=YELLOW, used[j]=1.
  - Otherwise code[i] remains ABSENT.
  - GREEN letters are skipped but still consume a cycle.
- COMMIT (1 cycle) writes the codes and characters to row guess_count and registers score_colors and score_row=guess_count. It also performs:
  - score_done=1 for exactly that cycle;
  - guess_count+1;
  - win set if all codes are GREEN;
  - lose set if the new count equals MAX_GUESSES and win is not set.
  - Then return to IDLE.
- Latency: score_done rises 2*WORD_LEN+1 edges after the accept edge (11 for defaults). Next accept is possible on the edge after score_done.
- A win on the final row gives win=1, lose=0.
- guess_valid while not ready is ignored; no buffering.
- clear is valid in any state and takes priority over all else: return to IDLE with history EMPTY, count=0, win=lose=0, no score_done. The target is retained.
- reset asserted mid-scoring: immediate return to reset values; target_valid=0.
- Read port:
  - rd_rgb and rd_char are registered from rd_row/rd_col on each edge.
  - rd_row >= MAX_GUESSES or rd_col >= WORD_LEN returns rd_rgb=3'b000, rd_char=8'h20.
  - A read of the row being committed returns the old contents on the commit edge and the new contents on the next edge.

Test Plan:
1. Reset, then load target "APPLE" and offer guess "PAPER". Required: score_done 11 cycles after accept; score_colors=10'b1010111001 (Y Y G Y A); guess_count=1.
2. Target "ABBEY", guess "BOBBY". Required: score_colors=10'b1001110111 (Y A G A G); the second extra B is ABSENT.
3. Target "CRANE", guess "CRANE". Required: colours all 11; win=1; guess_ready=0 afterwards; further guess_valid produces no score_done.
4. Six non-matching guesses ("ZZZZZ" vs "CRANE"). Required: rows 0..5 ABSENT; lose=1 on the 6th score_done; guess_count=6.
5. Assert clear at the 4th cycle of YELLOW. Required: no score_done; busy=0 next cycle; guess_count=0; reading row 0 col 0 gives rd_rgb=3'b111 one cycle later.
6. After test 1, read row 0 col 2 then row 7 col 0. Required: rd_rgb=3'b010 with rd_char="P", then 3'b000 with 8'h20, each one cycle after the address.

Source files
------------

// File: rtl/wordle_guess_scorer.sv
// rtl/wordle_guess_scorer.sv - Wordle guess scoring engine with scored-row history and registered display read port.
// Two-pass scan (exact matches, then lowest unused target letter) at one letter per cycle.
module wordle_guess_scorer #(
  parameter int WORD_LEN    = 5,
  parameter int CHAR_W      = 8,
  parameter int MAX_GUESSES = 6,
  parameter int ROW_W       = 3,
  parameter int COL_W       = 3
) (
  input  logic                       board_clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       target_load,
  input  logic [WORD_LEN*CHAR_W-1:0] target_word,
  input  logic                       guess_valid,
  input  logic [WORD_LEN*CHAR_W-1:0] guess_word,
  output logic                       guess_ready,
  output logic                       busy,
  output logic                       score_done,
  output logic [2*WORD_LEN-1:0]      score_colors,
  output logic [ROW_W-1:0]           score_row,
  output logic [ROW_W-1:0]           guess_count,
  output logic                       win,
  output logic                       lose,
  input  logic [ROW_W-1:0]           rd_row,
  input  logic [COL_W-1:0]           rd_col,
  output logic [2:0]                 rd_rgb,
  output logic [CHAR_W-1:0]          rd_char
);

  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_COMMIT} state_t;

  localparam logic [1:0] C_EMPTY  = 2'b00;
  localparam logic [1:0] C_ABSENT = 2'b01;
  localparam logic [1:0] C_YELLOW = 2'b10;
  localparam logic [1:0] C_GREEN  = 2'b11;
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(8'h20);

  state_t                      state_q, state_d;
  logic [WORD_LEN*CHAR_W-1:0]  target_q, target_d, guess_q, guess_d;
  logic                        target_valid_q, target_valid_d;
  logic [WORD_LEN-1:0]         used_q, used_d;
  logic [1:0]                  code_q [WORD_LEN];
  logic [1:0]                  code_d [WORD_LEN];
  logic [COL_W-1:0]            idx_q, idx_d;
  logic [1:0]                  hist_code_q [MAX_GUESSES][WORD_LEN];
  logic [1:0]                  hist_code_d [MAX_GUESSES][WORD_LEN];
  logic [CHAR_W-1:0]           hist_char_q [MAX_GUESSES][WORD_LEN];
  logic [CHAR_W-1:0]           hist_char_d [MAX_GUESSES][WORD_LEN];
  logic [ROW_W-1:0]            count_q, count_d, score_row_q, score_row_d;
  logic                        win_q, win_d, lose_q, lose_d, score_done_q, score_done_d;
  logic [2*WORD_LEN-1:0]       score_colors_q, score_colors_d;
  logic [2:0]                  rd_rgb_q, rd_rgb_d;
  logic [CHAR_W-1:0]           rd_char_q, rd_char_d;

  logic [CHAR_W-1:0]           t_l [WORD_LEN];
  logic [CHAR_W-1:0]           g_l [WORD_LEN];
  logic                        wipe, found, all_green;
  logic [COL_W-1:0]            jsel;

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      t_l[i] = target_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
      g_l[i] = guess_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
    end
  end

  assign guess_ready  = (state_q == S_IDLE) & target_valid_q & ~win_q & ~lose_q & ~clear;
  assign busy         = (state_q != S_IDLE);
  assign score_done   = score_done_q;
  assign score_colors = score_colors_q;
  assign score_row    = score_row_q;
  assign guess_count  = count_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign rd_rgb       = rd_rgb_q;
  assign rd_char      = rd_char_q;

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    guess_d        = guess_q;
    used_d         = used_q;
    code_d         = code_q;
    idx_d          = idx_q;
    hist_code_d    = hist_code_q;
    hist_char_d    = hist_char_q;
    count_d        = count_q;
    win_d          = win_q;
    lose_d         = lose_q;
    score_done_d   = 1'b0;
    score_colors_d = score_colors_q;
    score_row_d    = score_row_q;
    wipe           = 1'b0;
    found          = 1'b0;
    jsel           = '0;
    all_green      = 1'b1;

    for (int i = 0; i < WORD_LEN; i++) all_green = all_green & (code_q[i] == C_GREEN);
    // Scan high to low so the last hit, i.e. the lowest free index, wins.
    for (int j = WORD_LEN-1; j >= 0; j--) begin
      if (!used_q[j] && t_l[j] == g_l[idx_q]) begin
        found = 1'b1;
        jsel  = COL_W'(j);
      end
    end

    if (clear) begin
      wipe    = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (target_load) begin
            target_d       = target_word;
            target_valid_d = 1'b1;
            wipe           = 1'b1;
          end else if (guess_valid && guess_ready) begin
            guess_d = guess_word;
            used_d  = '0;
            idx_d   = '0;
            state_d = S_GREEN;
          end
        end
        S_GREEN: begin
          if (g_l[idx_q] == t_l[idx_q]) begin
            code_d[idx_q] = C_GREEN;
            used_d[idx_q] = 1'b1;
          end else begin
            code_d[idx_q] = C_ABSENT;
          end
          if (idx_q == COL_W'(WORD_LEN-1)) begin
            idx_d   = '0;
            state_d = S_YELLOW;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_YELLOW: begin
          if (code_q[idx_q] != C_GREEN && found) begin
            code_d[idx_q] = C_YELLOW;
            used_d[jsel]  = 1'b1;
          end
          if (idx_q == COL_W'(WORD_LEN-1)) begin
            idx_d   = '0;
            state_d = S_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_COMMIT: begin
          if (count_q < ROW_W'(MAX_GUESSES)) begin
            for (int c = 0; c < WORD_LEN; c++) begin
              hist_code_d[count_q][c] = code_q[c];
              hist_char_d[count_q][c] = g_l[c];
            end
          end
          for (int i = 0; i < WORD_LEN; i++) score_colors_d[(WORD_LEN-1-i)*2 +: 2] = code_q[i];
          score_row_d  = count_q;
          score_done_d = 1'b1;
          count_d      = count_q + 1'b1;
          win_d        = win_q | all_green;
          lose_d       = ((count_q + 1'b1) == ROW_W'(MAX_GUESSES)) & ~(win_q | all_green);
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (wipe) begin
      count_d      = '0;
      win_d        = 1'b0;
      lose_d       = 1'b0;
      score_done_d = 1'b0;
      for (int r = 0; r < MAX_GUESSES; r++) begin
        for (int c = 0; c < WORD_LEN; c++) begin
          hist_code_d[r][c] = C_EMPTY;
          hist_char_d[r][c] = BLANK;
        end
      end
    end
  end

  always_comb begin
    rd_rgb_d  = 3'b000;
    rd_char_d = BLANK;
    if (rd_row < ROW_W'(MAX_GUESSES) && rd_col < COL_W'(WORD_LEN)) begin
      rd_char_d = hist_char_q[rd_row][rd_col];
      case (hist_code_q[rd_row][rd_col])
        C_ABSENT: rd_rgb_d = 3'b101;
        C_YELLOW: rd_rgb_d = 3'b110;
        C_GREEN:  rd_rgb_d = 3'b010;
        default:  rd_rgb_d = 3'b111;
      endcase
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      guess_q        <= '0;
      used_q         <= '0;
      idx_q          <= '0;
      count_q        <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      score_done_q   <= 1'b0;
      score_colors_q <= '0;
      score_row_q    <= '0;
      rd_rgb_q       <= 3'b000;
      rd_char_q      <= '0;
      for (int c = 0; c < WORD_LEN; c++) code_q[c] <= C_EMPTY;
      for (int r = 0; r < MAX_GUESSES; r++) begin
        for (int c = 0; c < WORD_LEN; c++) begin
          hist_code_q[r][c] <= C_EMPTY;
          hist_char_q[r][c] <= BLANK;
        end
      end
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      guess_q        <= guess_d;
      used_q         <= used_d;
      code_q         <= code_d;
      idx_q          <= idx_d;
      hist_code_q    <= hist_code_d;
      hist_char_q    <= hist_char_d;
      count_q        <= count_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      score_done_q   <= score_done_d;
      score_colors_q <= score_colors_d;
      score_row_q    <= score_row_d;
      rd_rgb_q       <= rd_rgb_d;
      rd_char_q      <= rd_char_d;
    end
  end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// tb/tb_wordle_guess_scorer.sv - Directed self-checking bench for wordle_guess_scorer.
module tb_wordle_guess_scorer;

  logic        board_clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        target_load = 1'b0;
  logic [39:0] target_word = '0;
  logic        guess_valid = 1'b0;
  logic [39:0] guess_word = '0;
  logic        guess_ready, busy, score_done, win, lose;
  logic [9:0]  score_colors;
  logic [2:0]  score_row, guess_count;
  logic [2:0]  rd_row = 3'd0;
  logic [2:0]  rd_col = 3'd0;
  logic [2:0]  rd_rgb;
  logic [7:0]  rd_char;

  int total = 0;
  int bad = 0;

  wordle_guess_scorer dut (
    .board_clk(board_clk), .reset(reset), .clear(clear),
    .target_load(target_load), .target_word(target_word),
    .guess_valid(guess_valid), .guess_word(guess_word),
    .guess_ready(guess_ready), .busy(busy), .score_done(score_done),
    .score_colors(score_colors), .score_row(score_row), .guess_count(guess_count),
    .win(win), .lose(lose), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb(rd_rgb), .rd_char(rd_char)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_target(input logic [39:0] w);
    @(negedge board_clk);
    target_word = w;
    target_load = 1'b1;
    @(negedge board_clk);
    target_load = 1'b0;
  endtask

  // Returns edges from accept to score_done, or -1 if it never came.
  task automatic run_guess(input logic [39:0] w, output int lat);
    @(negedge board_clk);
    guess_word  = w;
    guess_valid = 1'b1;
    chk("ready_before_accept", guess_ready, 1);
    @(posedge board_clk);
    @(negedge board_clk);
    guess_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge board_clk);
      @(negedge board_clk);
      lat++;
      if (score_done) break;
    end
    if (!score_done) lat = -1;
  endtask

  initial begin
    int lat;
    int pulses;
    int busy_seen;

    repeat (3) @(negedge board_clk);
    chk("rst_ready", guess_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", score_done, 0);
    chk("rst_count", guess_count, 0);
    chk("rst_winlose", {win, lose}, 0);
    chk("rst_colors", score_colors, 0);
    chk("rst_rgb", rd_rgb, 0);
    reset = 1'b0;
    @(negedge board_clk);
    chk("rst_hist_rgb", rd_rgb, 3'b111);
    chk("rst_hist_char", rd_char, 8'h20);
    chk("no_target_ready", guess_ready, 0);

    // APPLE / PAPER
    load_target("APPLE");
    run_guess("PAPER", lat);
    chk("t1_latency", lat, 11);
    chk("t1_colors", score_colors, 10'b1010111001);
    chk("t1_count", guess_count, 1);
    chk("t1_row", score_row, 0);
    chk("t1_busy", busy, 0);
    @(negedge board_clk);
    chk("t1_done_pulse", score_done, 0);

    // Display reads of the committed row and an out-of-range row
    rd_row = 3'd0; rd_col = 3'd2;
    @(negedge board_clk);
    chk("t6_rgb_green", rd_rgb, 3'b010);
    chk("t6_char_p", rd_char, "P");
    rd_row = 3'd7; rd_col = 3'd0;
    @(negedge board_clk);
    chk("t6_rgb_oob", rd_rgb, 3'b000);
    chk("t6_char_oob", rd_char, 8'h20);
    rd_row = 3'd0; rd_col = 3'd5;
    @(negedge board_clk);
    chk("t6_col_oob", rd_rgb, 3'b000);

    // ABBEY / BOBBY duplicate handling
    load_target("ABBEY");
    run_guess("BOBBY", lat);
    chk("t2_latency", lat, 11);
    chk("t2_colors", score_colors, 10'b1001110111);
    chk("t2_count", guess_count, 1);
    chk("t2_win", win, 0);

    // CRANE / CRANE win, then further guesses ignored
    load_target("CRANE");
    run_guess("CRANE", lat);
    chk("t3_latency", lat, 11);
    chk("t3_colors", score_colors, 10'h3FF);
    chk("t3_win", win, 1);
    chk("t3_lose", lose, 0);
    @(negedge board_clk);
    chk("t3_ready_after_win", guess_ready, 0);
    guess_valid = 1'b1;
    pulses = 0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge board_clk);
      if (score_done) pulses++;
      if (busy) busy_seen++;
    end
    guess_valid = 1'b0;
    chk("t3_no_done", pulses, 0);
    chk("t3_no_busy", busy_seen, 0);

    // Six misses lose the game
    load_target("CRANE");
    chk("t4_win_cleared", win, 0);
    for (int k = 0; k < 6; k++) begin
      run_guess("ZZZZZ", lat);
      chk("t4_latency", lat, 11);
      chk("t4_colors", score_colors, 10'b0101010101);
      chk("t4_row", score_row, k);
      chk("t4_lose", lose, (k == 5));
    end
    chk("t4_count", guess_count, 6);
    chk("t4_win", win, 0);
    chk("t4_ready", guess_ready, 0);
    for (int r = 0; r < 6; r++) begin
      rd_row = 3'(r); rd_col = 3'd0;
      @(negedge board_clk);
      chk("t4_hist_absent", rd_rgb, 3'b101);
      chk("t4_hist_char", rd_char, "Z");
    end

    // Clear during the YELLOW pass aborts scoring and wipes history
    load_target("APPLE");
    run_guess("PAPER", lat);
    chk("t5_pre_latency", lat, 11);
    rd_row = 3'd0; rd_col = 3'd0;
    @(negedge board_clk);
    chk("t5_pre_rgb", rd_rgb, 3'b110);
    guess_word  = "PAPER";
    guess_valid = 1'b1;
    @(posedge board_clk);
    @(negedge board_clk);
    guess_valid = 1'b0;
    repeat (8) @(negedge board_clk);
    chk("t5_busy_before_clear", busy, 1);
    clear = 1'b1;
    @(negedge board_clk);
    clear = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", score_done, 0);
    chk("t5_count", guess_count, 0);
    @(negedge board_clk);
    chk("t5_rgb_empty", rd_rgb, 3'b111);
    chk("t5_char_blank", rd_char, 8'h20);
    pulses = 0;
    repeat (15) begin
      @(negedge board_clk);
      if (score_done) pulses++;
    end
    chk("t5_no_done", pulses, 0);
    chk("t5_ready", guess_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
